// File: rtl/mul_node_pkg.sv
// Shared FSM encoding and IEEE-754 field helpers for the product-node sequencer.
package mul_node_pkg;

  typedef enum logic [2:0] {
    GET_FIRST = 3'd0,
    GET_NEXT  = 3'd1,
    SEND_A    = 3'd2,
    SEND_B    = 3'd3,
    WAIT_Z    = 3'd4,
    PUT_Z     = 3'd5
  } state_t;

  localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] FP_QNAN        = 32'hFFC00000;

  // Sign bit is masked off so that +0 and -0 both count as zero.
  function automatic logic fp_is_zero(input logic [31:0] x);
    return (x & 32'h7FFF_FFFF) == 32'd0;
  endfunction

  function automatic logic fp_is_inf_nan(input logic [31:0] x);
    return ((x >> 23) & 32'h0000_00FF) == {24'd0, FP_EXP_SPECIAL};
  endfunction

endpackage

// File: rtl/mul_node_seq.sv
// Product-node sequencer: folds NUM_IN children through an external multiplier, >=2 cycles per handshake.
// Holds out_z and keeps in_ack low until out_z transfers; MUL_NODE_ZERO_SKIP_EN bypasses the multiplier on a zero accumulator.
module mul_node_seq
  import mul_node_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] mul_a,
  output logic        mul_a_stb,
  input  logic        mul_a_ack,
  output logic [31:0] mul_b,
  output logic        mul_b_stb,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic [31:0] out_z,
  output logic        out_z_stb,
  input  logic        out_z_ack,
  output logic        busy
);

  localparam int CW = $clog2(NUM_IN) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_IN);

  state_t        state, state_nxt;
  logic [31:0]   acc, acc_nxt;
  logic [31:0]   opnd, opnd_nxt;
  logic [31:0]   mul_a_nxt, mul_b_nxt, out_z_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          in_ack_nxt, mul_a_stb_nxt, mul_b_stb_nxt, mul_z_ack_nxt, out_z_stb_nxt;

  assign busy = (state != GET_FIRST);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    opnd_nxt      = opnd;
    cnt_nxt       = cnt;
    mul_a_nxt     = mul_a;
    mul_b_nxt     = mul_b;
    out_z_nxt     = out_z;
    in_ack_nxt    = in_ack;
    mul_a_stb_nxt = mul_a_stb;
    mul_b_stb_nxt = mul_b_stb;
    mul_z_ack_nxt = mul_z_ack;
    out_z_stb_nxt = out_z_stb;

    case (state)
      GET_FIRST: begin
        if (in_stb && in_ack) begin
          acc_nxt    = in_data;
          cnt_nxt    = CW'(1);
          in_ack_nxt = 1'b0;
          state_nxt  = (NUM_IN == 1) ? PUT_Z : GET_NEXT;
        end else begin
          in_ack_nxt = 1'b1;
        end
      end
      GET_NEXT: begin
        if (in_stb && in_ack) begin
          opnd_nxt   = in_data;
          cnt_nxt    = cnt + CW'(1);
          in_ack_nxt = 1'b0;
          state_nxt  = SEND_A;
`ifdef MUL_NODE_ZERO_SKIP_EN
          // A zero accumulator times any finite child is a signed zero; inf/NaN still needs the multiplier.
          if (fp_is_zero(acc) && !fp_is_inf_nan(in_data)) begin
            acc_nxt   = {acc[31] ^ in_data[31], 31'd0};
            state_nxt = (cnt + CW'(1) == LAST) ? PUT_Z : GET_NEXT;
          end
`endif
        end else begin
          in_ack_nxt = 1'b1;
        end
      end
      SEND_A: begin
        mul_a_nxt = acc;
        if (mul_a_stb && mul_a_ack) begin
          mul_a_stb_nxt = 1'b0;
          state_nxt     = SEND_B;
        end else begin
          mul_a_stb_nxt = 1'b1;
        end
      end
      SEND_B: begin
        mul_b_nxt = opnd;
        if (mul_b_stb && mul_b_ack) begin
          mul_b_stb_nxt = 1'b0;
          state_nxt     = WAIT_Z;
        end else begin
          mul_b_stb_nxt = 1'b1;
        end
      end
      WAIT_Z: begin
        if (mul_z_ack && mul_z_stb) begin
          acc_nxt       = mul_z;
          mul_z_ack_nxt = 1'b0;
          state_nxt     = (cnt == LAST) ? PUT_Z : GET_NEXT;
        end else begin
          mul_z_ack_nxt = 1'b1;
        end
      end
      PUT_Z: begin
        out_z_nxt = acc;
        if (out_z_stb && out_z_ack) begin
          out_z_stb_nxt = 1'b0;
          state_nxt     = GET_FIRST;
        end else begin
          out_z_stb_nxt = 1'b1;
        end
      end
      default: state_nxt = GET_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_FIRST;
      cnt       <= '0;
      in_ack    <= 1'b0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      mul_z_ack <= 1'b0;
      out_z_stb <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      in_ack    <= in_ack_nxt;
      mul_a_stb <= mul_a_stb_nxt;
      mul_b_stb <= mul_b_stb_nxt;
      mul_z_ack <= mul_z_ack_nxt;
      out_z_stb <= out_z_stb_nxt;
    end
  end

  // Data registers carry no reset; their strobes gate every use.
  always_ff @(posedge clk) begin
    acc   <= acc_nxt;
    opnd  <= opnd_nxt;
    mul_a <= mul_a_nxt;
    mul_b <= mul_b_nxt;
    out_z <= out_z_nxt;
  end

endmodule

// File: tb/tb_mul_node_seq.sv
// Directed bench for mul_node_seq with a behavioural multiplier on the a/b/z ports.
module tb_mul_node_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] in_data, mul_a, mul_b, out_z;
  logic        in_stb, in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_z_stb, out_z_ack, busy;
  logic [31:0] m_z;
  logic        m_a_ack, m_b_ack, m_z_stb;

  logic [31:0] p_in_data, p_mul_a, p_mul_b, p_out_z;
  logic        p_in_stb, p_in_ack, p_mul_a_stb, p_mul_b_stb, p_mul_z_ack, p_out_z_stb, p_out_z_ack, p_busy;

  int tests = 0;
  int fails = 0;

  mul_node_seq #(.NUM_IN(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(m_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(m_b_ack),
    .mul_z(m_z), .mul_z_stb(m_z_stb), .mul_z_ack(mul_z_ack),
    .out_z(out_z), .out_z_stb(out_z_stb), .out_z_ack(out_z_ack),
    .busy(busy)
  );

  mul_node_seq #(.NUM_IN(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(p_in_data), .in_stb(p_in_stb), .in_ack(p_in_ack),
    .mul_a(p_mul_a), .mul_a_stb(p_mul_a_stb), .mul_a_ack(1'b0),
    .mul_b(p_mul_b), .mul_b_stb(p_mul_b_stb), .mul_b_ack(1'b0),
    .mul_z(32'd0), .mul_z_stb(1'b0), .mul_z_ack(p_mul_z_ack),
    .out_z(p_out_z), .out_z_stb(p_out_z_stb), .out_z_ack(p_out_z_ack),
    .busy(p_busy)
  );

  // Truncating single-precision multiply: adequate for normal operands whose product is exact.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'hFFC00000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:0] == 0 || b[30:0] == 0) return 32'hFFC00000;
      return {s, 8'hFF, 23'd0};
    end
    if (a[30:0] == 0 || b[30:0] == 0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      return {s, e[7:0], p[46:24]};
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  int          mst = 0;
  int          mdly = 0;
  logic [31:0] ma, mb;
  int          a_xfers = 0;
  int          a_stb_cyc = 0;
  int          p_mul_cyc = 0;

  always @(posedge clk) begin
    if (rst) begin
      mst <= 0; m_a_ack <= 1'b0; m_b_ack <= 1'b0; m_z_stb <= 1'b0;
    end else begin
      case (mst)
        0: if (m_a_ack && mul_a_stb) begin ma <= mul_a; m_a_ack <= 1'b0; mst <= 1; end
           else m_a_ack <= 1'b1;
        1: if (m_b_ack && mul_b_stb) begin mb <= mul_b; m_b_ack <= 1'b0; mst <= 2; mdly <= 3; end
           else m_b_ack <= 1'b1;
        2: if (mdly == 0) begin m_z <= fp_mul(ma, mb); m_z_stb <= 1'b1; mst <= 3; end
           else mdly <= mdly - 1;
        default: if (m_z_stb && mul_z_ack) begin m_z_stb <= 1'b0; mst <= 0; end
      endcase
    end
    if (!rst && mul_a_stb && m_a_ack) a_xfers <= a_xfers + 1;
    if (mul_a_stb) a_stb_cyc <= a_stb_cyc + 1;
    if (p_mul_a_stb || p_mul_b_stb || p_mul_z_ack) p_mul_cyc <= p_mul_cyc + 1;
  end

  task automatic send_child(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    in_data = d;
    in_stb  = 1'b1;
    while (!in_ack && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ack) begin
      tests++; fails++;
      $display("FAIL send_child timeout: in_ack=%b required 1", in_ack);
    end
    @(posedge clk);
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_z_stb && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = out_z_stb;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_out timeout: out_z_stb=%b required 1", out_z_stb);
    end
  endtask

  task automatic get_result(output logic [31:0] z);
    bit ok;
    wait_out(ok);
    z = out_z;
    out_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_z_ack = 1'b0;
  endtask

  task automatic run_node(input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] c3,
                          output logic [31:0] z);
    send_child(c0);
    send_child(c1);
    send_child(c2);
    send_child(c3);
    get_result(z);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (in_ack !== 1'b0)    begin fails++; $display("FAIL reset_in_ack: got %b want 0", in_ack); end
    tests++; if (mul_a_stb !== 1'b0) begin fails++; $display("FAIL reset_mul_a_stb: got %b want 0", mul_a_stb); end
    tests++; if (mul_b_stb !== 1'b0) begin fails++; $display("FAIL reset_mul_b_stb: got %b want 0", mul_b_stb); end
    tests++; if (mul_z_ack !== 1'b0) begin fails++; $display("FAIL reset_mul_z_ack: got %b want 0", mul_z_ack); end
    tests++; if (out_z_stb !== 1'b0) begin fails++; $display("FAIL reset_out_z_stb: got %b want 0", out_z_stb); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (p_in_ack !== 1'b0 || p_busy !== 1'b0)
      begin fails++; $display("FAIL reset_pass_dut: in_ack=%b busy=%b want 0 0", p_in_ack, p_busy); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL reset_release_in_ack: got %b want 1", in_ack); end
  endtask

  task automatic test_basic_product();
    logic [31:0] z;
    int a0;
    a0 = a_xfers;
    send_child(32'h40000000);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_mid: got %b want 1", busy); end
    send_child(32'h40400000);
    send_child(32'h3F000000);
    send_child(32'h40800000);
    get_result(z);
    tests++; if (z !== 32'h41400000) begin fails++; $display("FAIL basic_out_z: got %h want 41400000", z); end
    tests++; if (a_xfers - a0 !== 3) begin fails++; $display("FAIL basic_mul_a_xfers: got %0d want 3", a_xfers - a0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_zero_absorb();
    logic [31:0] z;
    int a0, s0;
    a0 = a_xfers;
    s0 = a_stb_cyc;
    run_node(32'h00000000, 32'h40000000, 32'h40400000, 32'h3F000000, z);
    tests++; if (z !== 32'h00000000) begin fails++; $display("FAIL zero_out_z: got %h want 00000000", z); end
`ifdef MUL_NODE_ZERO_SKIP_EN
    tests++; if (a_stb_cyc - s0 !== 0) begin fails++; $display("FAIL zero_skip_mul_a_stb: high %0d cycles want 0", a_stb_cyc - s0); end
`else
    tests++; if (a_xfers - a0 !== 3) begin fails++; $display("FAIL zero_mul_a_xfers: got %0d want 3 (stb cycles %0d)", a_xfers - a0, a_stb_cyc - s0); end
`endif
  endtask

  task automatic test_signed_zero_inf();
    logic [31:0] z;
    run_node(32'h80000000, 32'h40000000, 32'h7F800000, 32'h3F800000, z);
    tests++; if (z !== 32'hFFC00000) begin fails++; $display("FAIL zero_inf_out_z: got %h want ffc00000", z); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit hold_ok;
    send_child(32'h3FC00000);
    send_child(32'h40000000);
    send_child(32'h40000000);
    send_child(32'h3F800000);
    wait_out(ok);
    hold_ok = ok;
    for (int i = 0; i < 10; i++) begin
      if (out_z_stb !== 1'b1 || out_z !== 32'h40C00000 || in_ack !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    tests++; if (!hold_ok) begin fails++; $display("FAIL bp_hold: stb=%b z=%h in_ack=%b want 1 40c00000 0", out_z_stb, out_z, in_ack); end
    out_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_z_ack = 1'b0;
    tests++; if (out_z_stb !== 1'b0 || in_ack !== 1'b0)
      begin fails++; $display("FAIL bp_single_xfer: stb=%b in_ack=%b want 0 0", out_z_stb, in_ack); end
    @(negedge clk);
    tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL bp_in_ack_rise: got %b want 1", in_ack); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int n = 0;
    send_child(32'h40000000);
    send_child(32'h40400000);
    while (!mul_z_ack && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++; if (mul_z_ack !== 1'b1) begin fails++; $display("FAIL rstmid_reach_wait_z: mul_z_ack=%b want 1", mul_z_ack); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++; if ({in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_z_stb, busy} !== 6'b0)
      begin fails++; $display("FAIL rstmid_outputs: in_ack,a,b,z_ack,out_stb,busy=%b want 000000",
                              {in_ack, mul_a_stb, mul_b_stb, mul_z_ack, out_z_stb, busy}); end
    run_node(32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000, z);
    tests++; if (z !== 32'h41400000) begin fails++; $display("FAIL rstmid_out_z: got %h want 41400000", z); end
  endtask

  task automatic test_pass_through();
    int n = 0;
    logic [31:0] z;
    @(negedge clk);
    p_in_data = 32'h3E800000;
    p_in_stb  = 1'b1;
    while (!p_in_ack && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    p_in_stb = 1'b0;
    n = 0;
    while (!p_out_z_stb && n < 100) begin @(negedge clk); n++; end
    z = p_out_z;
    tests++; if (p_out_z_stb !== 1'b1 || z !== 32'h3E800000)
      begin fails++; $display("FAIL pass_out_z: stb=%b z=%h want 1 3e800000", p_out_z_stb, z); end
    p_out_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    p_out_z_ack = 1'b0;
    tests++; if (p_mul_cyc !== 0) begin fails++; $display("FAIL pass_no_mul: handshake cycles %0d want 0", p_mul_cyc); end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_stb = 1'b0; out_z_ack = 1'b0;
    p_in_data = '0; p_in_stb = 1'b0; p_out_z_ack = 1'b0;
    test_reset();
    test_basic_product();
    test_zero_absorb();
    test_signed_zero_inf();
    test_backpressure();
    test_reset_mid();
    test_pass_through();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
